// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: one outstanding IMEM read, redirect kill, hold under pipe stall.
// Define FETCH_PERF_EN to add saturating fetch/kill counters (fetch_cnt_o, kill_cnt_o).
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        ACLK,
    input  logic        ARESETn,
    input  logic        redirect_i,
    input  logic [31:0] redirect_addr_i,
    input  logic        pipe_stall_i,
    output logic        imem_req_valid_o,
    output logic [31:0] imem_req_addr_o,
    input  logic        imem_req_ready_i,
    input  logic        imem_rsp_valid_i,
    input  logic [31:0] imem_rsp_data_i,
    output logic        fetch_valid_o,
    output logic [31:0] fetch_pc_o,
    output logic [31:0] fetch_instr_o,
`ifdef FETCH_PERF_EN
    output logic [31:0] fetch_cnt_o,
    output logic [31:0] kill_cnt_o,
`endif
    output logic        if_stall_o
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t      state, state_d;
    logic [31:0] req_pc, req_pc_d;
    logic [31:0] redir_pc, redir_pc_d;
    logic        kill, kill_d;
    logic [31:0] fetch_pc_q;
    logic [31:0] instr_q;
    logic        capture, handover, discard, req_valid;
    logic [31:0] target;

    assign target = {redirect_addr_i[31:2], 2'b00};

    logic unused_addr_bits;
    assign unused_addr_bits = ^redirect_addr_i[1:0];

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state;
        req_pc_d   = req_pc;
        redir_pc_d = redir_pc;
        kill_d     = kill;
        capture    = 1'b0;
        handover   = 1'b0;
        discard    = 1'b0;
        req_valid  = 1'b0;
        case (state)
            S_REQ: begin
                req_valid = 1'b1;
                // The request stays up even when redirected; its response is killed later.
                if (redirect_i) begin
                    kill_d     = 1'b1;
                    redir_pc_d = target;
                end
                if (imem_req_ready_i) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (imem_rsp_valid_i) begin
                    if (kill || redirect_i) begin
                        discard  = 1'b1;
                        req_pc_d = redirect_i ? target : redir_pc;
                        kill_d   = 1'b0;
                        state_d  = S_REQ;
                    end else begin
                        capture = 1'b1;
                        state_d = S_HOLD;
                    end
                end else if (redirect_i) begin
                    kill_d     = 1'b1;
                    redir_pc_d = target;
                end
            end
            S_HOLD: begin
                if (redirect_i) begin
                    req_pc_d = target;
                    state_d  = S_REQ;
                end else if (!pipe_stall_i) begin
                    handover = 1'b1;
                    req_pc_d = req_pc + 32'd4;
                    state_d  = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state      <= S_REQ;
            req_pc     <= RESET_PC;
            redir_pc   <= RESET_PC;
            kill       <= 1'b0;
            fetch_pc_q <= RESET_PC;
        end else begin
            state    <= state_d;
            req_pc   <= req_pc_d;
            redir_pc <= redir_pc_d;
            kill     <= kill_d;
            if (capture) fetch_pc_q <= req_pc;
        end
    end

    // NOTE: the instruction register needs no reset; the output is masked to NOP unless in HOLD.
    always_ff @(posedge ACLK) begin
        if (capture) instr_q <= imem_rsp_data_i;
    end

    assign imem_req_valid_o = req_valid && ARESETn;
    assign imem_req_addr_o  = req_pc;
    assign fetch_valid_o    = (state == S_HOLD);
    assign fetch_pc_o       = fetch_pc_q;
    assign fetch_instr_o    = (state == S_HOLD) ? instr_q : NOP_INSTR;
    assign if_stall_o       = !handover;

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_cnt, kill_cnt;

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            fetch_cnt <= '0;
            kill_cnt  <= '0;
        end else begin
            if (handover && fetch_cnt != 32'hFFFF_FFFF) fetch_cnt <= fetch_cnt + 32'd1;
            if (discard && kill_cnt != 32'hFFFF_FFFF)   kill_cnt  <= kill_cnt + 32'd1;
        end
    end

    assign fetch_cnt_o = fetch_cnt;
    assign kill_cnt_o  = kill_cnt;
`else
    logic unused_perf;
    assign unused_perf = discard;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: per-cycle stimulus/expectation tables with hand-computed values.
// A second instance with RESET_PC=32'hFFFF_FFFC covers PC wraparound and reset-in-WAIT.
module tb_fetch_ctrl;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        ACLK;
    logic        ARESETn;
    logic        redirect_i;
    logic [31:0] redirect_addr_i;
    logic        pipe_stall_i;
    logic        imem_req_ready_i;
    logic        imem_rsp_valid_i;
    logic [31:0] imem_rsp_data_i;

    logic        req_valid_a, fvalid_a, stall_a;
    logic [31:0] req_addr_a, fpc_a, finstr_a;
    logic        req_valid_b, fvalid_b, stall_b;
    logic [31:0] req_addr_b, fpc_b, finstr_b;
`ifdef FETCH_PERF_EN
    logic [31:0] fetch_cnt_a, kill_cnt_a, fetch_cnt_b, kill_cnt_b;
`endif

    int checks   = 0;
    int failures = 0;

    fetch_ctrl dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .redirect_i(redirect_i), .redirect_addr_i(redirect_addr_i),
        .pipe_stall_i(pipe_stall_i),
        .imem_req_valid_o(req_valid_a), .imem_req_addr_o(req_addr_a),
        .imem_req_ready_i(imem_req_ready_i),
        .imem_rsp_valid_i(imem_rsp_valid_i), .imem_rsp_data_i(imem_rsp_data_i),
        .fetch_valid_o(fvalid_a), .fetch_pc_o(fpc_a), .fetch_instr_o(finstr_a),
`ifdef FETCH_PERF_EN
        .fetch_cnt_o(fetch_cnt_a), .kill_cnt_o(kill_cnt_a),
`endif
        .if_stall_o(stall_a)
    );

    fetch_ctrl #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .redirect_i(redirect_i), .redirect_addr_i(redirect_addr_i),
        .pipe_stall_i(pipe_stall_i),
        .imem_req_valid_o(req_valid_b), .imem_req_addr_o(req_addr_b),
        .imem_req_ready_i(imem_req_ready_i),
        .imem_rsp_valid_i(imem_rsp_valid_i), .imem_rsp_data_i(imem_rsp_data_i),
        .fetch_valid_o(fvalid_b), .fetch_pc_o(fpc_b), .fetch_instr_o(finstr_b),
`ifdef FETCH_PERF_EN
        .fetch_cnt_o(fetch_cnt_b), .kill_cnt_o(kill_cnt_b),
`endif
        .if_stall_o(stall_b)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    typedef struct packed {
        logic        rst_n;
        logic        redirect;
        logic [31:0] raddr;
        logic        stall;
        logic        ready;
        logic        rsp_valid;
        logic [31:0] rdata;
    } stim_t;

    typedef struct packed {
        logic        req_valid;
        logic [31:0] req_addr;
        logic        fvalid;
        logic [31:0] fpc;
        logic [31:0] finstr;
        logic        if_stall;
    } exp_t;

    function automatic stim_t mk_s(input logic rst_n, input logic redirect, input logic [31:0] raddr,
                                   input logic stall, input logic ready, input logic rsp_valid,
                                   input logic [31:0] rdata);
        return '{rst_n, redirect, raddr, stall, ready, rsp_valid, rdata};
    endfunction

    function automatic exp_t mk_e(input logic rv, input logic [31:0] ra, input logic fv,
                                  input logic [31:0] fpc, input logic [31:0] fi, input logic st);
        return '{rv, ra, fv, fpc, fi, st};
    endfunction

    function automatic exp_t sample_a();
        return '{req_valid_a, req_addr_a, fvalid_a, fpc_a, finstr_a, stall_a};
    endfunction

    function automatic exp_t sample_b();
        return '{req_valid_b, req_addr_b, fvalid_b, fpc_b, finstr_b, stall_b};
    endfunction

    // Inputs change at the falling edge; outputs are read 1 ns later, well before the rising edge.
    task automatic drive(input stim_t s);
        @(negedge ACLK);
        ARESETn          = s.rst_n;
        redirect_i       = s.redirect;
        redirect_addr_i  = s.raddr;
        pipe_stall_i     = s.stall;
        imem_req_ready_i = s.ready;
        imem_rsp_valid_i = s.rsp_valid;
        imem_rsp_data_i  = s.rdata;
        #1;
    endtask

    task automatic do_reset();
        for (int i = 0; i < 2; i++) drive(mk_s(0, 0, 0, 0, 0, 0, 0));
    endtask

    task automatic test_reset();
        stim_t s[$];
        exp_t  e[$];
        exp_t  obs;
        do_reset();
        s.push_back(mk_s(0, 0, 0, 0, 1, 0, 0));           e.push_back(mk_e(0, 0, 0, 0, NOP, 1));
        s.push_back(mk_s(1, 0, 0, 0, 1, 0, 0));           e.push_back(mk_e(1, 0, 0, 0, NOP, 1));
        s.push_back(mk_s(1, 0, 0, 0, 0, 0, 0));           e.push_back(mk_e(0, 0, 0, 0, NOP, 1));
        s.push_back(mk_s(0, 0, 0, 0, 0, 0, 0));           e.push_back(mk_e(0, 0, 0, 0, NOP, 1));
        s.push_back(mk_s(1, 0, 0, 0, 0, 1, 32'hDEAD_BEEF)); e.push_back(mk_e(1, 0, 0, 0, NOP, 1));
        s.push_back(mk_s(1, 0, 0, 0, 0, 0, 0));           e.push_back(mk_e(1, 0, 0, 0, NOP, 1));
        for (int i = 0; i < s.size(); i++) begin
            drive(s[i]);
            obs = sample_a();
            checks++;
            if (obs !== e[i]) begin
                failures++;
                $display("FAIL reset[%0d] got=%h exp=%h", i, obs, e[i]);
            end
        end
`ifdef FETCH_PERF_EN
        checks++;
        if (fetch_cnt_a !== 32'd0 || kill_cnt_a !== 32'd0) begin
            failures++;
            $display("FAIL reset_counters got=%0d/%0d exp=0/0", fetch_cnt_a, kill_cnt_a);
        end
`endif
    endtask

    task automatic test_sequential();
        stim_t s[$];
        exp_t  e[$];
        exp_t  obs;
        do_reset();
        s.push_back(mk_s(1, 0, 0, 0, 1, 0, 0));            e.push_back(mk_e(1, 32'h0, 0, 32'h0, NOP, 1));
        s.push_back(mk_s(1, 0, 0, 0, 1, 1, 32'h1111_1111)); e.push_back(mk_e(0, 32'h0, 0, 32'h0, NOP, 1));
        s.push_back(mk_s(1, 0, 0, 0, 1, 0, 0));            e.push_back(mk_e(0, 32'h0, 1, 32'h0, 32'h1111_1111, 0));
        s.push_back(mk_s(1, 0, 0, 0, 1, 0, 0));            e.push_back(mk_e(1, 32'h4, 0, 32'h0, NOP, 1));
        s.push_back(mk_s(1, 0, 0, 0, 1, 1, 32'h2222_2222)); e.push_back(mk_e(0, 32'h4, 0, 32'h0, NOP, 1));
        s.push_back(mk_s(1, 0, 0, 0, 1, 0, 0));            e.push_back(mk_e(0, 32'h4, 1, 32'h4, 32'h2222_2222, 0));
        s.push_back(mk_s(1, 0, 0, 0, 1, 0, 0));            e.push_back(mk_e(1, 32'h8, 0, 32'h4, NOP, 1));
        s.push_back(mk_s(1, 0, 0, 0, 1, 1, 32'h3333_3333)); e.push_back(mk_e(0, 32'h8, 0, 32'h4, NOP, 1));
        s.push_back(mk_s(1, 0, 0, 0, 1, 0, 0));            e.push_back(mk_e(0, 32'h8, 1, 32'h8, 32'h3333_3333, 0));
        s.push_back(mk_s(1, 0, 0, 0, 0, 0, 0));            e.push_back(mk_e(1, 32'hC, 0, 32'h8, NOP, 1));
        for (int i = 0; i < s.size(); i++) begin
            drive(s[i]);
            obs = sample_a();
            checks++;
            if (obs !== e[i]) begin
                failures++;
                $display("FAIL sequential[%0d] got=%h exp=%h", i, obs, e[i]);
            end
        end
`ifdef FETCH_PERF_EN
        checks++;
        if (fetch_cnt_a !== 32'd3 || kill_cnt_a !== 32'd0) begin
            failures++;
            $display("FAIL sequential_counters got=%0d/%0d exp=3/0", fetch_cnt_a, kill_cnt_a);
        end
`endif
    endtask

    task automatic test_ready_backpressure();
        stim_t s[$];
        exp_t  e[$];
        exp_t  obs;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            s.push_back(mk_s(1, 0, 0, 0, 0, 0, 0));        e.push_back(mk_e(1, 32'h0, 0, 32'h0, NOP, 1));
        end
        s.push_back(mk_s(1, 0, 0, 0, 1, 0, 0));            e.push_back(mk_e(1, 32'h0, 0, 32'h0, NOP, 1));
        s.push_back(mk_s(1, 0, 0, 0, 1, 0, 0));            e.push_back(mk_e(0, 32'h0, 0, 32'h0, NOP, 1));
        s.push_back(mk_s(1, 0, 0, 0, 1, 1, 32'h4444_4444)); e.push_back(mk_e(0, 32'h0, 0, 32'h0, NOP, 1));
        s.push_back(mk_s(1, 0, 0, 0, 0, 0, 0));            e.push_back(mk_e(0, 32'h0, 1, 32'h0, 32'h4444_4444, 0));
        s.push_back(mk_s(1, 0, 0, 0, 0, 0, 0));            e.push_back(mk_e(1, 32'h4, 0, 32'h0, NOP, 1));
        for (int i = 0; i < s.size(); i++) begin
            drive(s[i]);
            obs = sample_a();
            checks++;
            if (obs !== e[i]) begin
                failures++;
                $display("FAIL backpressure[%0d] got=%h exp=%h", i, obs, e[i]);
            end
        end
    endtask

    task automatic test_redirect_wait();
        stim_t s[$];
        exp_t  e[$];
        exp_t  obs;
        do_reset();
        s.push_back(mk_s(1, 0, 0, 0, 1, 0, 0));              e.push_back(mk_e(1, 32'h0, 0, 32'h0, NOP, 1));
        s.push_back(mk_s(1, 1, 32'h100, 0, 0, 0, 0));        e.push_back(mk_e(0, 32'h0, 0, 32'h0, NOP, 1));
        s.push_back(mk_s(1, 0, 0, 0, 0, 0, 0));              e.push_back(mk_e(0, 32'h0, 0, 32'h0, NOP, 1));
        s.push_back(mk_s(1, 0, 0, 0, 1, 1, 32'h5555_5555));  e.push_back(mk_e(0, 32'h0, 0, 32'h0, NOP, 1));
        s.push_back(mk_s(1, 0, 0, 0, 1, 0, 0));              e.push_back(mk_e(1, 32'h100, 0, 32'h0, NOP, 1));
        s.push_back(mk_s(1, 0, 0, 0, 1, 1, 32'h6666_6666));  e.push_back(mk_e(0, 32'h100, 0, 32'h0, NOP, 1));
        s.push_back(mk_s(1, 0, 0, 0, 0, 0, 0));              e.push_back(mk_e(0, 32'h100, 1, 32'h100, 32'h6666_6666, 0));
        s.push_back(mk_s(1, 0, 0, 0, 0, 0, 0));              e.push_back(mk_e(1, 32'h104, 0, 32'h100, NOP, 1));
        for (int i = 0; i < s.size(); i++) begin
            drive(s[i]);
            obs = sample_a();
            checks++;
            if (obs !== e[i]) begin
                failures++;
                $display("FAIL redirect_wait[%0d] got=%h exp=%h", i, obs, e[i]);
            end
        end
`ifdef FETCH_PERF_EN
        checks++;
        if (fetch_cnt_a !== 32'd1 || kill_cnt_a !== 32'd1) begin
            failures++;
            $display("FAIL redirect_wait_counters got=%0d/%0d exp=1/1", fetch_cnt_a, kill_cnt_a);
        end
`endif
    endtask

    task automatic test_redirect_req();
        stim_t s[$];
        exp_t  e[$];
        exp_t  obs;
        do_reset();
        s.push_back(mk_s(1, 1, 32'h300, 0, 0, 0, 0));        e.push_back(mk_e(1, 32'h0, 0, 32'h0, NOP, 1));
        s.push_back(mk_s(1, 1, 32'h400, 0, 0, 0, 0));        e.push_back(mk_e(1, 32'h0, 0, 32'h0, NOP, 1));
        s.push_back(mk_s(1, 0, 0, 0, 1, 0, 0));              e.push_back(mk_e(1, 32'h0, 0, 32'h0, NOP, 1));
        s.push_back(mk_s(1, 0, 0, 0, 0, 1, 32'h7777_0000));  e.push_back(mk_e(0, 32'h0, 0, 32'h0, NOP, 1));
        s.push_back(mk_s(1, 0, 0, 0, 0, 0, 0));              e.push_back(mk_e(1, 32'h400, 0, 32'h0, NOP, 1));
        for (int i = 0; i < s.size(); i++) begin
            drive(s[i]);
            obs = sample_a();
            checks++;
            if (obs !== e[i]) begin
                failures++;
                $display("FAIL redirect_req[%0d] got=%h exp=%h", i, obs, e[i]);
            end
        end
    endtask

    task automatic test_stall_hold();
        stim_t s[$];
        exp_t  e[$];
        exp_t  obs;
        do_reset();
        s.push_back(mk_s(1, 0, 0, 0, 1, 0, 0));              e.push_back(mk_e(1, 32'h0, 0, 32'h0, NOP, 1));
        s.push_back(mk_s(1, 0, 0, 0, 1, 1, 32'h7777_7777));  e.push_back(mk_e(0, 32'h0, 0, 32'h0, NOP, 1));
        for (int i = 0; i < 5; i++) begin
            s.push_back(mk_s(1, 0, 0, 1, 1, 0, 0));          e.push_back(mk_e(0, 32'h0, 1, 32'h0, 32'h7777_7777, 1));
        end
        s.push_back(mk_s(1, 0, 0, 0, 1, 0, 0));              e.push_back(mk_e(0, 32'h0, 1, 32'h0, 32'h7777_7777, 0));
        s.push_back(mk_s(1, 0, 0, 0, 0, 0, 0));              e.push_back(mk_e(1, 32'h4, 0, 32'h0, NOP, 1));
        for (int i = 0; i < s.size(); i++) begin
            drive(s[i]);
            obs = sample_a();
            checks++;
            if (obs !== e[i]) begin
                failures++;
                $display("FAIL stall_hold[%0d] got=%h exp=%h", i, obs, e[i]);
            end
        end
    endtask

    task automatic test_redirect_hold();
        stim_t s[$];
        exp_t  e[$];
        exp_t  obs;
        do_reset();
        s.push_back(mk_s(1, 0, 0, 0, 1, 0, 0));              e.push_back(mk_e(1, 32'h0, 0, 32'h0, NOP, 1));
        s.push_back(mk_s(1, 0, 0, 0, 1, 1, 32'h8888_8888));  e.push_back(mk_e(0, 32'h0, 0, 32'h0, NOP, 1));
        s.push_back(mk_s(1, 0, 0, 1, 1, 0, 0));              e.push_back(mk_e(0, 32'h0, 1, 32'h0, 32'h8888_8888, 1));
        s.push_back(mk_s(1, 1, 32'h40, 1, 1, 0, 0));         e.push_back(mk_e(0, 32'h0, 1, 32'h0, 32'h8888_8888, 1));
        s.push_back(mk_s(1, 0, 0, 0, 1, 0, 0));              e.push_back(mk_e(1, 32'h40, 0, 32'h0, NOP, 1));
        s.push_back(mk_s(1, 0, 0, 0, 1, 1, 32'h9999_9999));  e.push_back(mk_e(0, 32'h40, 0, 32'h0, NOP, 1));
        s.push_back(mk_s(1, 0, 0, 0, 0, 0, 0));              e.push_back(mk_e(0, 32'h40, 1, 32'h40, 32'h9999_9999, 0));
        for (int i = 0; i < s.size(); i++) begin
            drive(s[i]);
            obs = sample_a();
            checks++;
            if (obs !== e[i]) begin
                failures++;
                $display("FAIL redirect_hold[%0d] got=%h exp=%h", i, obs, e[i]);
            end
        end
`ifdef FETCH_PERF_EN
        checks++;
        if (fetch_cnt_a !== 32'd0 || kill_cnt_a !== 32'd0) begin
            failures++;
            $display("FAIL redirect_hold_counters got=%0d/%0d exp=0/0", fetch_cnt_a, kill_cnt_a);
        end
`endif
    endtask

    task automatic test_redirect_at_rsp();
        stim_t s[$];
        exp_t  e[$];
        exp_t  obs;
        do_reset();
        s.push_back(mk_s(1, 0, 0, 0, 1, 0, 0));              e.push_back(mk_e(1, 32'h0, 0, 32'h0, NOP, 1));
        s.push_back(mk_s(1, 1, 32'h203, 0, 0, 1, 32'hAAAA_0000)); e.push_back(mk_e(0, 32'h0, 0, 32'h0, NOP, 1));
        s.push_back(mk_s(1, 0, 0, 0, 0, 0, 0));              e.push_back(mk_e(1, 32'h200, 0, 32'h0, NOP, 1));
        for (int i = 0; i < s.size(); i++) begin
            drive(s[i]);
            obs = sample_a();
            checks++;
            if (obs !== e[i]) begin
                failures++;
                $display("FAIL redirect_at_rsp[%0d] got=%h exp=%h", i, obs, e[i]);
            end
        end
`ifdef FETCH_PERF_EN
        checks++;
        if (kill_cnt_a !== 32'd1) begin
            failures++;
            $display("FAIL redirect_at_rsp_kill_cnt got=%0d exp=1", kill_cnt_a);
        end
`endif
    endtask

    task automatic test_wrap_and_reset_wait();
        stim_t s[$];
        exp_t  e[$];
        exp_t  obs;
        do_reset();
        s.push_back(mk_s(0, 0, 0, 0, 1, 0, 0));              e.push_back(mk_e(0, 32'hFFFF_FFFC, 0, 32'hFFFF_FFFC, NOP, 1));
        s.push_back(mk_s(1, 0, 0, 0, 1, 0, 0));              e.push_back(mk_e(1, 32'hFFFF_FFFC, 0, 32'hFFFF_FFFC, NOP, 1));
        s.push_back(mk_s(1, 0, 0, 0, 1, 1, 32'hBBBB_BBBB));  e.push_back(mk_e(0, 32'hFFFF_FFFC, 0, 32'hFFFF_FFFC, NOP, 1));
        s.push_back(mk_s(1, 0, 0, 0, 1, 0, 0));              e.push_back(mk_e(0, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 32'hBBBB_BBBB, 0));
        s.push_back(mk_s(1, 0, 0, 0, 1, 0, 0));              e.push_back(mk_e(1, 32'h0, 0, 32'hFFFF_FFFC, NOP, 1));
        s.push_back(mk_s(1, 0, 0, 0, 0, 0, 0));              e.push_back(mk_e(0, 32'h0, 0, 32'hFFFF_FFFC, NOP, 1));
        s.push_back(mk_s(0, 0, 0, 0, 0, 0, 0));              e.push_back(mk_e(0, 32'h0, 0, 32'hFFFF_FFFC, NOP, 1));
        s.push_back(mk_s(1, 0, 0, 0, 1, 0, 0));              e.push_back(mk_e(1, 32'hFFFF_FFFC, 0, 32'hFFFF_FFFC, NOP, 1));
        for (int i = 0; i < s.size(); i++) begin
            drive(s[i]);
            obs = sample_b();
            checks++;
            if (obs !== e[i]) begin
                failures++;
                $display("FAIL wrap_reset[%0d] got=%h exp=%h", i, obs, e[i]);
            end
        end
    endtask

    initial begin
        ARESETn          = 1'b0;
        redirect_i       = 1'b0;
        redirect_addr_i  = '0;
        pipe_stall_i     = 1'b0;
        imem_req_ready_i = 1'b0;
        imem_rsp_valid_i = 1'b0;
        imem_rsp_data_i  = '0;
        test_reset();
        test_sequential();
        test_ready_backpressure();
        test_redirect_wait();
        test_redirect_req();
        test_stall_hold();
        test_redirect_hold();
        test_redirect_at_rsp();
        test_wrap_and_reset_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
